// File: rtl/bitmap_access_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : bitmap_access_sequencer_if
// Brief  : Groups the CPU, video, auto-increment and RAM signals of the bitmap
//          access sequencer. master = sequencer view, slave = environment view.
// Rev    : 1.0 - initial release
// ============================================================================
interface bitmap_access_sequencer_if;
    logic        ce2Hd;
    logic        cpu_req;
    logic        cpu_wr;
    logic [3:0]  cpu_wd;
    logic        ax_en;
    logic        ay_en;
    logic [14:0] drba;
    logic        pixa;
    logic        vid_req;
    logic [14:0] vid_addr;
    logic [7:0]  ram_din;
    logic [14:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic [1:0]  ram_wmask;
    logic        BITMDn;
    logic        AXn;
    logic        AYn;
    logic [3:0]  cpu_rd;
    logic        cpu_done;
    logic [7:0]  vid_data;
    logic        vid_ack;
    logic        busy;

    modport master (
        input  ce2Hd, cpu_req, cpu_wr, cpu_wd, ax_en, ay_en, drba, pixa,
               vid_req, vid_addr, ram_din,
        output ram_addr, ram_dout, ram_we, ram_wmask, BITMDn, AXn, AYn,
               cpu_rd, cpu_done, vid_data, vid_ack, busy
    );

    modport slave (
        output ce2Hd, cpu_req, cpu_wr, cpu_wd, ax_en, ay_en, drba, pixa,
               vid_req, vid_addr, ram_din,
        input  ram_addr, ram_dout, ram_we, ram_wmask, BITMDn, AXn, AYn,
               cpu_rd, cpu_done, vid_data, vid_ack, busy
    );
endinterface
`default_nettype wire

// File: rtl/bitmap_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module : bitmap_access_sequencer
// Brief  : Arbitrates the bitmap RAM between video fetch and CPU pixel access.
//          Define BITMAP_RMW_EN for read-modify-write pixel writes; otherwise
//          writes use nibble lane masks and skip the read tick.
// Rev    : 1.0 - initial release
// ============================================================================
module bitmap_access_sequencer #(
    parameter int STARVE_MAX = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    bitmap_access_sequencer_if.master    bus
);
    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VID    = 3'd1,
        S_CPU_RD = 3'd2,
        S_CPU_WR = 3'd3,
        S_INC    = 3'd4
    } state_t;

    state_t      r_state;
    logic [3:0]  r_starve;
    logic [7:0]  r_ram_dout;
    logic        r_ram_we;
    logic [1:0]  r_ram_wmask;
    logic        r_bitmdn;
    logic        r_axn;
    logic        r_ayn;
    logic [3:0]  r_cpu_rd;
    logic        r_cpu_done;
    logic [7:0]  r_vid_data;
    logic        r_vid_ack;
    logic [14:0] w_ram_addr;
    logic [3:0]  w_rd_nib;

    assign w_rd_nib = bus.pixa ? bus.ram_din[7:4] : bus.ram_din[3:0];

    always_comb begin
        w_ram_addr = 15'd0;
        case (r_state)
            S_VID:              w_ram_addr = bus.vid_addr;
            S_CPU_RD, S_CPU_WR: w_ram_addr = bus.drba;
            default:            w_ram_addr = 15'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_starve    <= 4'd0;
            r_ram_dout  <= 8'd0;
            r_ram_we    <= 1'b0;
            r_ram_wmask <= 2'b00;
            r_bitmdn    <= 1'b1;
            r_axn       <= 1'b1;
            r_ayn       <= 1'b1;
            r_cpu_rd    <= 4'd0;
            r_cpu_done  <= 1'b0;
            r_vid_data  <= 8'd0;
            r_vid_ack   <= 1'b0;
        end else begin
            // completion strobes are one clk wide regardless of ce2Hd
            r_cpu_done <= 1'b0;
            r_vid_ack  <= 1'b0;
            if (bus.ce2Hd) begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.vid_req && (!bus.cpu_req || (r_starve < c_starve_max))) begin
                            r_state <= S_VID;
                        end else if (bus.cpu_req) begin
                            r_bitmdn <= 1'b0;
`ifdef BITMAP_RMW_EN
                            r_state  <= S_CPU_RD;
`else
                            if (bus.cpu_wr) begin
                                r_state     <= S_CPU_WR;
                                r_ram_we    <= 1'b1;
                                r_ram_wmask <= bus.pixa ? 2'b10 : 2'b01;
                                r_ram_dout  <= {bus.cpu_wd, bus.cpu_wd};
                            end else begin
                                r_state <= S_CPU_RD;
                            end
`endif
                        end
                    end
                    S_VID: begin
                        r_vid_data <= bus.ram_din;
                        r_vid_ack  <= 1'b1;
                        if (bus.cpu_req && (r_starve != 4'hF)) begin
                            r_starve <= r_starve + 4'd1;
                        end
                        r_state <= S_IDLE;
                    end
                    S_CPU_RD: begin
                        r_cpu_rd <= w_rd_nib;
`ifdef BITMAP_RMW_EN
                        if (bus.cpu_wr) begin
                            // the merged byte doubles as the read buffer
                            r_state     <= S_CPU_WR;
                            r_ram_we    <= 1'b1;
                            r_ram_wmask <= 2'b11;
                            r_ram_dout  <= bus.pixa ? {bus.cpu_wd, bus.ram_din[3:0]}
                                                    : {bus.ram_din[7:4], bus.cpu_wd};
                        end else begin
                            r_state <= S_INC;
                            r_axn   <= ~bus.ax_en;
                            r_ayn   <= ~bus.ay_en;
                        end
`else
                        r_state <= S_INC;
                        r_axn   <= ~bus.ax_en;
                        r_ayn   <= ~bus.ay_en;
`endif
                    end
                    S_CPU_WR: begin
                        r_ram_we    <= 1'b0;
                        r_ram_wmask <= 2'b00;
                        r_axn       <= ~bus.ax_en;
                        r_ayn       <= ~bus.ay_en;
                        r_state     <= S_INC;
                    end
                    S_INC: begin
                        r_bitmdn   <= 1'b1;
                        r_axn      <= 1'b1;
                        r_ayn      <= 1'b1;
                        r_cpu_done <= 1'b1;
                        r_starve   <= 4'd0;
                        r_state    <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.ram_addr  = w_ram_addr;
    assign bus.ram_dout  = r_ram_dout;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_wmask = r_ram_wmask;
    assign bus.BITMDn    = r_bitmdn;
    assign bus.AXn       = r_axn;
    assign bus.AYn       = r_ayn;
    assign bus.cpu_rd    = r_cpu_rd;
    assign bus.cpu_done  = r_cpu_done;
    assign bus.vid_data  = r_vid_data;
    assign bus.vid_ack   = r_vid_ack;
    assign bus.busy      = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_bitmap_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_bitmap_access_sequencer
// Brief  : Scoreboard bench for bitmap_access_sequencer with a byte-array RAM
//          model and an independent pixel-level reference memory.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_bitmap_access_sequencer;
    localparam int c_starve_max = 4;
`ifdef BITMAP_RMW_EN
    localparam bit c_rmw = 1'b1;
`else
    localparam bit c_rmw = 1'b0;
`endif
    localparam logic [43:0] c_reset_outs = {15'h0, 8'h0, 1'b0, 2'b00, 3'b111,
                                            4'h0, 1'b0, 8'h0, 1'b0, 1'b0};

    typedef struct {
        logic [3:0] rd;
        int         ax;
        int         ay;
        int         we;
    } cpu_exp_t;

    logic clk = 1'b0;
    logic reset;
    bitmap_access_sequencer_if bus();

    bitmap_access_sequencer #(.STARVE_MAX(c_starve_max)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ce_mode = 0;
    bit sb_on = 1'b1;
    logic load_ram = 1'b0;
    logic [3:0] model_rd = 4'h0;
    logic [7:0] ram_mem [0:32767];
    logic [7:0] ref_mem [0:32767];
    cpu_exp_t cpu_q [$];
    logic [7:0] vid_q [$];
    bit events [$];

    int tick_cnt = 0, clk_cnt = 0;
    int ax_ticks = 0, ay_ticks = 0, we_ticks = 0, ax_clks = 0, ay_clks = 0;
    logic [14:0] last_waddr = '0;
    logic [7:0]  last_wdout = '0;
    logic [1:0]  last_wmask = '0;

    logic [43:0] w_outs;
    assign w_outs = {bus.ram_addr, bus.ram_dout, bus.ram_we, bus.ram_wmask, bus.BITMDn,
                     bus.AXn, bus.AYn, bus.cpu_rd, bus.cpu_done, bus.vid_data,
                     bus.vid_ack, bus.busy};
    assign bus.ram_din = ram_mem[bus.ram_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // RAM model and event counters, all sampled at the clk edge
    always @(posedge clk) begin
        clk_cnt <= clk_cnt + 1;
        if (!reset) begin
            if (!bus.AXn) ax_clks <= ax_clks + 1;
            if (!bus.AYn) ay_clks <= ay_clks + 1;
            if (bus.ce2Hd) begin
                tick_cnt <= tick_cnt + 1;
                if (!bus.AXn) ax_ticks <= ax_ticks + 1;
                if (!bus.AYn) ay_ticks <= ay_ticks + 1;
                if (bus.ram_we) begin
                    we_ticks   <= we_ticks + 1;
                    last_waddr <= bus.ram_addr;
                    last_wdout <= bus.ram_dout;
                    last_wmask <= bus.ram_wmask;
                    ram_mem[bus.ram_addr] <= {bus.ram_wmask[1] ? bus.ram_dout[7:4] : ram_mem[bus.ram_addr][7:4],
                                              bus.ram_wmask[0] ? bus.ram_dout[3:0] : ram_mem[bus.ram_addr][3:0]};
                end
            end
        end
        if (load_ram) for (int i = 0; i < 32768; i++) ram_mem[i] <= ref_mem[i];
    end

    initial begin
        bus.ce2Hd = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ce_mode)
                0:       bus.ce2Hd = 1'b1;
                1:       bus.ce2Hd = ((clk_cnt % 4) == 0);
                default: bus.ce2Hd = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // monitor: pops the scoreboard whenever a completion strobe appears
    initial begin
        cpu_exp_t e;
        int ax_mark, ay_mark, we_mark;
        ax_mark = 0; ay_mark = 0; we_mark = 0;
        forever begin
            @(negedge clk);
            if (bus.cpu_done) begin
                if (!sb_on) events.push_back(1'b1);
                else begin
                    check("cpu queue nonempty at cpu_done", 64'(cpu_q.size() != 0), 64'd1);
                    if (cpu_q.size() != 0) begin
                        e = cpu_q.pop_front();
                        check("cpu_rd", 64'(bus.cpu_rd), 64'(e.rd));
                        check("AX step ticks", 64'(ax_ticks - ax_mark), 64'(e.ax));
                        check("AY step ticks", 64'(ay_ticks - ay_mark), 64'(e.ay));
                        check("ram_we ticks", 64'(we_ticks - we_mark), 64'(e.we));
                    end
                end
                ax_mark = ax_ticks; ay_mark = ay_ticks; we_mark = we_ticks;
            end
            if (bus.vid_ack) begin
                if (!sb_on) events.push_back(1'b0);
                else begin
                    check("vid queue nonempty at vid_ack", 64'(vid_q.size() != 0), 64'd1);
                    if (vid_q.size() != 0) check("vid_data", 64'(bus.vid_data), 64'(vid_q.pop_front()));
                end
            end
        end
    end

    // lat_idx: tick index of cpu_done counting the sampling IDLE tick as 0
    task automatic cpu_access(input logic wr, input logic [3:0] wd, input logic [14:0] a,
                              input logic p, input logic axe, input logic aye,
                              output int lat_idx, output int lat_clk);
        cpu_exp_t e;
        logic [7:0] old;
        int n, t0, c0;
        old = ref_mem[a];
        if (!wr || c_rmw) model_rd = p ? old[7:4] : old[3:0];
        if (wr) ref_mem[a] = p ? {wd, old[3:0]} : {old[7:4], wd};
        e.rd = model_rd; e.ax = int'(axe); e.ay = int'(aye); e.we = int'(wr);
        cpu_q.push_back(e);
        bus.cpu_wr = wr; bus.cpu_wd = wd; bus.drba = a; bus.pixa = p;
        bus.ax_en = axe; bus.ay_en = aye; bus.cpu_req = 1'b1;
        n = 0;
        while (!bus.busy && n < 400) begin @(negedge clk); n++; end
        t0 = tick_cnt; c0 = clk_cnt;
        n = 0;
        while (!bus.cpu_done && n < 400) begin @(negedge clk); n++; end
        check("cpu_done arrives", 64'(bus.cpu_done), 64'd1);
        lat_idx = tick_cnt - t0 + 1;
        lat_clk = clk_cnt - c0;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("cpu_done width", 64'(bus.cpu_done), 64'd0);
    endtask

    task automatic vid_fetch(input logic [14:0] a, output int lat_idx, output int lat_clk);
        int n, t0, c0;
        vid_q.push_back(ref_mem[a]);
        bus.vid_addr = a; bus.vid_req = 1'b1;
        n = 0;
        while (!bus.busy && n < 400) begin @(negedge clk); n++; end
        t0 = tick_cnt; c0 = clk_cnt;
        n = 0;
        while (!bus.vid_ack && n < 400) begin @(negedge clk); n++; end
        check("vid_ack arrives", 64'(bus.vid_ack), 64'd1);
        lat_idx = tick_cnt - t0 + 1;
        lat_clk = clk_cnt - c0;
        bus.vid_req = 1'b0;
        @(negedge clk);
        check("vid_ack width", 64'(bus.vid_ack), 64'd0);
    endtask

    initial begin
        int li, lc, li2, lc2, n, a0, y0;
        bit seen;
        reset = 1'b1;
        bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_wd = 0; bus.ax_en = 0; bus.ay_en = 0;
        bus.drba = 0; bus.pixa = 0; bus.vid_req = 0; bus.vid_addr = 0;
        for (int i = 0; i < 32768; i++) ref_mem[i] = 8'($urandom);
        ref_mem[15'h1234] = 8'hA5;
        ref_mem[15'h0010] = 8'h3C;
        ref_mem[15'h0020] = 8'h3C;
        repeat (2) @(negedge clk);
        load_ram = 1'b1;
        @(negedge clk);
        load_ram = 1'b0;
        check("reset outputs", 64'(w_outs), 64'(c_reset_outs));
        reset = 1'b0;
        @(negedge clk);

        cpu_access(1'b0, 4'h0, 15'h1234, 1'b1, 1'b1, 1'b0, li, lc);
        check("read latency", 64'(li), 64'd3);

        cpu_access(1'b1, 4'h7, 15'h0010, 1'b0, 1'b0, 1'b0, li, lc);
        check("write latency", 64'(li), c_rmw ? 64'd4 : 64'd3);
        check("write addr", 64'(last_waddr), 64'h0010);
        check("write data", 64'(last_wdout), c_rmw ? 64'h37 : 64'h77);
        check("write mask", 64'(last_wmask), c_rmw ? 64'd3 : 64'd1);

        cpu_access(1'b1, 4'h5, 15'h0020, 1'b1, 1'b0, 1'b1, li, lc);
        check("hi write latency", 64'(li), c_rmw ? 64'd4 : 64'd3);
        check("hi write data", 64'(last_wdout), c_rmw ? 64'h5C : 64'h55);
        check("hi write mask", 64'(last_wmask), c_rmw ? 64'd3 : 64'd2);

        // one tick every four clks
        ce_mode = 1;
        repeat (4) @(negedge clk);
        a0 = ax_clks; y0 = ay_clks;
        cpu_access(1'b0, 4'h0, 15'h1234, 1'b0, 1'b1, 1'b1, li, lc);
        check("gated read latency", 64'(li), 64'd3);
        check("gated read clks", 64'(lc), 64'd8);
        check("AXn low clks", 64'(ax_clks - a0), 64'd4);
        check("AYn low clks", 64'(ay_clks - y0), 64'd4);
        vid_fetch(15'h4100, li, lc);
        check("gated vid latency", 64'(li), 64'd2);
        check("gated vid clks", 64'(lc), 64'd4);

        ce_mode = 2;
        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [14:0] ca, va;
            logic wr, p, axe, aye;
            logic [3:0] wd;
            kind = $urandom_range(0, 2);
            ca = 15'($urandom_range(0, 31));
            va = 15'h4000 + 15'($urandom_range(0, 31));
            wr = 1'($urandom); p = 1'($urandom); axe = 1'($urandom); aye = 1'($urandom);
            wd = 4'($urandom);
            case (kind)
                0: cpu_access(wr, wd, ca, p, axe, aye, li, lc);
                1: vid_fetch(va, li2, lc2);
                default: fork
                    cpu_access(wr, wd, ca, p, axe, aye, li, lc);
                    vid_fetch(va, li2, lc2);
                join
            endcase
        end

        ce_mode = 0;
        repeat (4) @(negedge clk);
        bus.cpu_wr = 1'b1; bus.cpu_wd = 4'h9; bus.drba = 15'h0030; bus.pixa = 1'b0;
        bus.ax_en = 1'b1; bus.ay_en = 1'b0; bus.cpu_req = 1'b1;
        n = 0;
        while (!bus.ram_we && n < 100) begin @(negedge clk); n++; end
        check("ram_we before reset", 64'(bus.ram_we), 64'd1);
        reset = 1'b1;
        #1;
        check("reset mid-write outputs", 64'(w_outs), 64'(c_reset_outs));
        bus.cpu_req = 1'b0;
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (bus.cpu_done) seen = 1'b1; end
        reset = 1'b0;
        model_rd = 4'h0;
        repeat (4) begin @(negedge clk); if (bus.cpu_done) seen = 1'b1; end
        check("no cpu_done after reset", 64'(seen), 64'd0);
        check("no write survives reset", 64'(ram_mem[15'h0030]), 64'(ref_mem[15'h0030]));

        // both requesters held: pattern must begin fresh from a cleared starve count
        sb_on = 1'b0;
        events.delete();
        bus.cpu_wr = 1'b0; bus.ax_en = 1'b0; bus.drba = 15'h0005;
        bus.vid_addr = 15'h4200; bus.cpu_req = 1'b1; bus.vid_req = 1'b1;
        n = 0;
        while (events.size() < 12 && n < 500) begin @(negedge clk); n++; end
        bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
        check("contention event count", 64'(events.size() >= 12), 64'd1);
        for (int i = 0; i < 12 && i < events.size(); i++)
            check("contention order", 64'(events[i]), 64'((i % (c_starve_max + 1)) == c_starve_max));
        repeat (20) @(negedge clk);
        sb_on = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bitmap_access_sequencer.md
Name: bitmap_access_sequencer

Overview:
- Sequences all accesses to the shared bitmap RAM. Grants the RAM either to the video line fetch or to a CPU pixel access.
- A CPU pixel access addresses the RAM through the X/Y auto-increment datapath. The sequencer drives that datapath's BITMDn, AXn and AYn controls.
- A CPU pixel write is a 4-bit nibble, performed as a read-modify-write of the RAM byte.
- Position: between the CPU bus decode, the video fetch logic, the auto-increment block and the bitmap RAM.

Parameters:
- STARVE_MAX, 4: consecutive video grants allowed while cpu_req is pending; at this count the CPU is granted next. Range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce2Hd  in  1  clock enable; all FSM transitions happen only on clk edges where ce2Hd=1 (a "tick")
- cpu_req  in  1  CPU pixel access pending (level); held until cpu_done
- cpu_wr  in  1  1=pixel write, 0=pixel read; stable while cpu_req=1
- cpu_wd  in  4  pixel write data
- ax_en  in  1  X auto-step enable after each CPU access
- ay_en  in  1  Y auto-step enable after each CPU access
- drba  in  15  pixel byte address from the auto-increment block
- pixa  in  1  nibble select from the auto-increment block
- vid_req  in  1  video fetch pending (level)
- vid_addr  in  15  video fetch address
- ram_din  in  8  RAM read data, valid in the same tick as the address
- ram_addr  out  15  RAM address
- ram_dout  out  8  RAM write data
- ram_we  out  1  RAM write strobe
- ram_wmask  out  2  byte-lane nibble enables {hi,lo}
- BITMDn  out  1  low = auto-increment block drives drba
- AXn  out  1  low = step X
- AYn  out  1  low = step Y
- cpu_rd  out  4  pixel read data
- cpu_done  out  1  one-clk pulse when the CPU access completes
- vid_data  out  8  fetched byte
- vid_ack  out  1  one-clk pulse when vid_data is valid
- busy  out  1  state != IDLE

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, starve_cnt=0.
  - ram_we=0, ram_wmask=0, BITMDn=1, AXn=1, AYn=1.
  - cpu_done=0, vid_ack=0, cpu_rd=0, vid_data=0, ram_addr=0, ram_dout=0.
- Reset mid-access: the FSM returns to IDLE at once and ram_we drops asynchronously. No completion pulse is issued; no partial write survives past reset.
- Every state lasts exactly one tick.
- IDLE:
  - vid_req=1 and (cpu_req=0 or starve_cnt<STARVE_MAX) -> VID.
  - Otherwise cpu_req=1 -> CPU_RD.
  - Otherwise stay in IDLE.
  - If both requests are present, video wins until the starvation limit is reached.
- VID:
  - ram_addr=vid_addr.
  - On exit: vid_data<=ram_din, vid_ack pulses for 1 clk.
  - starve_cnt increments (saturating at 15) if cpu_req=1.
  - -> IDLE.
- CPU_RD:
  - BITMDn=0, ram_addr=drba.
  - On exit: latch ram_din into rbuf; cpu_rd<=pixa ? ram_din[7:4] : ram_din[3:0].
  - cpu_wr=1 -> CPU_WR; otherwise -> INC.
- CPU_WR:
  - BITMDn=0, ram_addr=drba, ram_we=1, ram_wmask=2'b11.
  - ram_dout = rbuf with nibble pixa replaced by cpu_wd.
  - -> INC.
- INC:
  - BITMDn=0, AXn=~ax_en, AYn=~ay_en, each held low for the whole tick so the datapath sees exactly one ce2Hd edge.
  - On exit: cpu_done pulses for 1 clk, starve_cnt<=0.
  - -> IDLE.
- Latency, measured from the tick where IDLE samples cpu_req:
  - CPU read: cpu_done 3 ticks later.
  - CPU write: cpu_done 4 ticks later.
  - Video fetch: vid_ack 2 ticks after its IDLE sample.
- Handshake:
  - The requester drops cpu_req within 1 clk of cpu_done.
  - If cpu_req is still high at the next IDLE tick, it is a new access.
  - vid_req follows the same rule with vid_ack.
- Coordinate wrap (255->0) is the datapath's concern; the sequencer only strobes.
- All outputs except the ram_addr mux are registered.

Optional Feature:
- BITMAP_RMW_EN
- Defined: behaviour exactly as described above (read-modify-write, ram_wmask=2'b11).
- Undefined: a CPU write goes IDLE->CPU_WR directly, skipping CPU_RD.
  - ram_dout={cpu_wd,cpu_wd}, ram_wmask = pixa ? 2'b10 : 2'b01.
  - cpu_rd is unchanged by writes.
  - Write latency becomes 3 ticks.
  - Requires nibble-writable RAM.

Test Plan:
- CPU read, no video: drba=0x1234, pixa=1, ram_din=0xA5, ax_en=1, ay_en=0 -> cpu_rd=0xA, cpu_done 3 ticks after sample, one AXn-low tick, AYn stays high, ram_we never asserted.
- CPU write (RMW on): drba=0x0010, pixa=0, ram_din=0x3C, cpu_wd=0x7 -> write tick with ram_addr=0x0010, ram_dout=0x37, ram_we=1 for exactly one tick; cpu_done at tick 4.
- Contention: vid_req and cpu_req held high continuously, STARVE_MAX=4 -> 4 vid_ack pulses, then one CPU access, then 4 more vid_ack pulses; pattern repeats.
- ce2Hd gating: ce2Hd high 1 of every 4 clks -> state advances only on enabled edges; AXn stays low for all 4 clks of the INC tick; cpu_done and vid_ack are exactly 1 clk wide.
- Reset asserted during CPU_WR -> ram_we=0 immediately, no cpu_done, all outputs at reset values; after release, IDLE with starve_cnt=0.
- RMW off: write with pixa=1, cpu_wd=0x5 -> no CPU_RD tick, ram_dout=0x55, ram_wmask=2'b10, cpu_done at tick 3.
